// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, state encoding and request type for the cache request driver
package cache_pkg;

  localparam int CACHE_ADDR_WIDTH  = 8;
  localparam int CACHE_DATA_WIDTH  = 8;
  localparam int CACHE_QUEUE_DEPTH = 4;
  localparam int CACHE_TIMEOUT     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } drv_state_t;

  typedef struct packed {
    logic                        we;
    logic [CACHE_ADDR_WIDTH-1:0] addr;
    logic [CACHE_DATA_WIDTH-1:0] wdata;
  } cache_req_t;

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - request queue with registered storage; head is the oldest entry
module req_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // full/empty come from the count only, so a same-cycle pop never frees a slot early
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cache_req_driver.sv
// rtl/cache_req_driver.sv - queues CPU requests and drives them one at a time onto the cache re/we/done handshake
module cache_req_driver
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = CACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH     = CACHE_DATA_WIDTH,
  parameter int QUEUE_DEPTH    = CACHE_QUEUE_DEPTH,
  parameter int TIMEOUT_CYCLES = CACHE_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  cache_re,
  output logic                  cache_we,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  input  logic                  cache_done,
  input  logic                  cache_op_in_progress,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_we,
  output logic                  resp_timeout,
  output logic                  busy,
  output logic                  spurious_done
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  drv_state_t            state;
  logic [CW-1:0]         cnt;
  logic                  op_we;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [REQ_W-1:0]      fifo_head;
  logic                  head_we;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  assign req_ready  = !fifo_full;
  assign fifo_push  = req_valid && !fifo_full;
  assign fifo_pop   = (state == IDLE) && !fifo_empty && !cache_op_in_progress;
  assign head_we    = fifo_head[REQ_W-1];
  assign head_addr  = fifo_head[DATA_WIDTH +: ADDR_WIDTH];
  assign head_wdata = fifo_head[DATA_WIDTH-1:0];

  assign cache_addr  = op_addr;
  assign cache_wdata = op_wdata;
  assign busy        = (state != IDLE) || !fifo_empty;

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({req_we, req_addr, req_wdata}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      op_we         <= 1'b0;
      op_addr       <= '0;
      op_wdata      <= '0;
      cache_re      <= 1'b0;
      cache_we      <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_we       <= 1'b0;
      resp_timeout  <= 1'b0;
      spurious_done <= 1'b0;
    end else begin
      // a done outside WAIT cannot belong to our request; flag it and otherwise ignore it
      if (cache_done && (state != WAIT)) spurious_done <= 1'b1;

      case (state)
        IDLE: begin
          if (fifo_pop) begin
            op_we    <= head_we;
            op_addr  <= head_addr;
            op_wdata <= head_wdata;
            cache_re <= !head_we;
            cache_we <= head_we;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cache_re <= 1'b0;
          cache_we <= 1'b0;
          cnt      <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // done takes priority over a timeout expiring in the same cycle
          if (cache_done) begin
            resp_valid   <= 1'b1;
            resp_rdata   <= op_we ? '0 : cache_rdata;
            resp_we      <= op_we;
            resp_timeout <= 1'b0;
            state        <= RESP;
          end else if (cnt == CNT_LAST) begin
            resp_valid   <= 1'b1;
            resp_rdata   <= '0;
            resp_we      <= op_we;
            resp_timeout <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_req_driver.md
Name: cache_req_driver

Overview:
- Requester-side initiator for the cache's re/we/done handshake.
- Buffers CPU-side requests in a small FIFO and issues them to the cache one at a time, as single-cycle re or we pulses.
- Holds the address and write data stable until the cache's done, then returns a response (read data or timeout) on a valid/ready port.
- Sits between the CPU/testbench request source and the cache top, whose done-generation logic consumes re/we/hit.

Parameters:
- ADDR_WIDTH, 8, cache address width.
- DATA_WIDTH, 8, cache data width.
- QUEUE_DEPTH, 4, request FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before the request is abandoned; ≥4.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept; equals !full.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cache_re  out  1  one-cycle read pulse to the cache.
- cache_we  out  1  one-cycle write pulse to the cache.
- cache_addr  out  ADDR_WIDTH  address to the cache, stable ISSUE through done.
- cache_wdata  out  DATA_WIDTH  write data to the cache, stable ISSUE through done.
- cache_rdata  in  DATA_WIDTH  read data from the cache, valid in the done cycle.
- cache_done  in  1  one-cycle completion pulse from the cache.
- cache_op_in_progress  in  1  cache pipeline is occupied.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_WIDTH  captured read data; 0 for writes and timeouts.
- resp_we  out  1  type of the completed operation.
- resp_timeout  out  1  operation abandoned because of timeout.
- busy  out  1  FSM is not in IDLE, or the FIFO is non-empty.
- spurious_done  out  1  sticky flag: done was seen outside WAIT.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE and the FIFO empties.
  - All outputs are 0, except req_ready=1.
  - Timeout counter = 0; spurious_done = 0.
- FIFO:
  - Push when req_valid & req_ready.
  - Registered: a pushed entry is visible the cycle after the push.
  - When full, req_ready=0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo QUEUE_DEPTH. A count register of width clog2(QUEUE_DEPTH)+1 distinguishes full from empty.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE -> ISSUE when FIFO non-empty & !cache_op_in_progress. Pop the head and latch we/addr/wdata into the operation registers.
  - ISSUE (exactly 1 cycle): cache_re = !op_we and cache_we = op_we; never both. -> WAIT, counter cleared.
  - WAIT: re/we = 0 and the counter increments each cycle.
    - cache_done=1 -> RESP. Latch resp_rdata = op_we ? 0 : cache_rdata; resp_timeout=0.
    - Counter reaches TIMEOUT_CYCLES-1 without done -> RESP with resp_timeout=1 and resp_rdata=0.
    - If done and the timeout occur in the same cycle, done wins.
  - RESP: resp_valid=1, holding rdata/we/timeout stable until resp_ready. Handshake cycle -> IDLE; the next issue is possible the following cycle.
- cache_addr/cache_wdata are driven from the operation registers and hold their values outside active operations.
- cache_done seen in IDLE, ISSUE or RESP sets spurious_done, which stays set until reset. The done is otherwise ignored.
- Latency:
  - Push at edge t → ISSUE during cycle t+1 → WAIT from t+2.
  - The response is valid the cycle after done.
- Throughput: at most one outstanding cache operation. There is no re/we re-assertion while cache_op_in_progress=1.
- A new push during WAIT/RESP is accepted if the FIFO is not full.

Decomposition:
- Package cache_pkg:
  - state enum typedef drv_state_t {IDLE, ISSUE, WAIT, RESP};
  - request struct typedef {we, addr, wdata} sized by the package ADDR_WIDTH/DATA_WIDTH constants;
  - default TIMEOUT constant.
- One sub-module, req_fifo: a parameterised synchronous FIFO with push/pop/full/empty/head.
- The FSM, timeout counter and response registers live in cache_req_driver.

Test Plan:
- Single read: push read addr 0x12; the cache returns done 3 cycles after ISSUE with rdata 0xA5.
  - Required: exactly one cache_re pulse and cache_addr=0x12 through done.
  - Required: resp_valid with rdata 0xA5, we=0, timeout=0.
- Write then read back-to-back: push write 0x05/0x3C, then read 0x05.
  - Required: cache_we pulse, then cache_re pulse, never overlapping.
  - Required: the second ISSUE occurs only after the first response handshake; write resp_rdata=0.
- FIFO full: push 5 requests with the cache stalled.
  - Required: req_ready drops after 4 accepted pushes (first issued + 3 queued? no: depth 4 means 4 queued).
  - Required: the 5th push is held until a pop; all responses arrive in push order.
- Timeout: push a read and never assert done.
  - Required: after 16 WAIT cycles, resp_valid with timeout=1 and rdata=0; the FSM returns to IDLE after resp_ready.
- Backpressure and op_in_progress:
  - Hold resp_ready=0 for 5 cycles. Required: the response stays stable.
  - Hold cache_op_in_progress=1 with a queued request. Required: no ISSUE until it drops.
- Reset mid-WAIT: rst=0 asynchronously while in WAIT.
  - Required: outputs clear immediately and the FIFO empties.
  - Required: a done arriving after reset release sets spurious_done=1.
